// File: rtl/seg_display_arbiter.sv
// Round-robin owner arbitration for the shared 32-bit seven-segment display value, with a minimum hold per grant.
// Optional macro SEG_ARB_PREEMPT_EN: requester 0 preempts any other owner during HOLD.
module seg_display_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int HOLD_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    grant,
  output logic [31:0]           disp_data,
  output logic                  disp_valid,
  output logic                  hold_done
);

  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(HOLD_CYCLES - 2);
  localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   last;
  logic               rr_found;
  logic [IDX_W-1:0]   rr_idx;
  logic [31:0]        rr_data;
  logic [31:0]        owner_data;
  logic [NUM_REQ-1:0] rr_onehot;

  // Search last+1 .. last+NUM_REQ; descending loop lets the nearest hit win, and
  // last itself (k == NUM_REQ) is considered only when no one else requests.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_REQ]) begin
        rr_found = 1'b1;
        rr_idx   = IDX_W'((int'(last) + k) % NUM_REQ);
      end
    end
  end

  assign rr_data    = req_data[32*int'(rr_idx) +: 32];
  assign owner_data = req_data[32*int'(last) +: 32];
  assign rr_onehot  = NUM_REQ'(1) << rr_idx;

  // NOTE: asynchronous reset clears every register, including disp_data, the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= IDX_INIT;
      grant      <= '0;
      disp_data  <= 32'h0;
      disp_valid <= 1'b0;
      hold_done  <= 1'b0;
    end else begin
      hold_done <= 1'b0;
      case (state)
        IDLE: begin
          grant <= '0;
          if (rr_found) begin
            grant      <= rr_onehot;
            disp_data  <= rr_data;
            last       <= rr_idx;
            cnt        <= '0;
            disp_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
`ifdef SEG_ARB_PREEMPT_EN
          if (req[0] && last != '0) begin
            grant     <= NUM_REQ'(1);
            disp_data <= req_data[31:0];
            cnt       <= '0;
            last      <= '0;
          end else
`endif
          if (cnt == CNT_LAST) begin
            if (rr_found) begin
              grant     <= rr_onehot;
              disp_data <= rr_data;
              last      <= rr_idx;
              cnt       <= '0;
            end else begin
              grant <= '0;
              cnt   <= '0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
            // hold_done is registered so it is high exactly while cnt sits at its last value.
            hold_done <= (cnt == CNT_PRE);
            if (req[last]) disp_data <= owner_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed, table-driven bench for seg_display_arbiter with NUM_REQ=3, HOLD_CYCLES=4.
module tb_seg_display_arbiter;

  localparam int NUM_REQ = 3;
  localparam int HOLD    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    req;
  logic [31:0]   d0, d1, d2;
  logic [95:0]   req_data;
  logic [2:0]    grant;
  logic [31:0]   disp_data;
  logic          disp_valid;
  logic          hold_done;

  int checks = 0;
  int errors = 0;

  assign req_data = {d2, d1, d0};

  always #5 clk = ~clk;

  seg_display_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .disp_data  (disp_data),
    .disp_valid (disp_valid),
    .hold_done  (hold_done)
  );

  typedef struct {
    logic [2:0]  req;
    logic [31:0] d0, d1, d2;
    logic [2:0]  grant;
    logic [31:0] data;
    logic        valid;
    logic        hd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] r, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [2:0] g, input logic [31:0] dd,
                              input logic v, input logic h);
    vec_t x;
    x.req = r; x.d0 = a; x.d1 = b; x.d2 = c;
    x.grant = g; x.data = dd; x.valid = v; x.hd = h;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] g, input logic [31:0] dd,
                           input logic v, input logic h);
    check({tag, " grant"}, 32'(grant), 32'(g));
    check({tag, " disp_data"}, disp_data, dd);
    check({tag, " disp_valid"}, 32'(disp_valid), 32'(v));
    check({tag, " hold_done"}, 32'(hold_done), 32'(h));
  endtask

  task automatic step(input logic [2:0] r, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c);
    req = r; d0 = a; d1 = b; d2 = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // idle, single requester, round-robin, owner drop, live tracking, hand-off to owner 2
    vecs.push_back(mk(3'b000, 0, 0, 0, 3'b000, 32'h0, 0, 0));                      // 0
    vecs.push_back(mk(3'b000, 0, 0, 0, 3'b000, 32'h0, 0, 0));
    vecs.push_back(mk(3'b001, 32'h1234ABCD, 0, 0, 3'b001, 32'h1234ABCD, 1, 0));    // 2
    vecs.push_back(mk(3'b001, 32'h1234ABCD, 0, 0, 3'b001, 32'h1234ABCD, 1, 0));
    vecs.push_back(mk(3'b001, 32'h1234ABCD, 0, 0, 3'b001, 32'h1234ABCD, 1, 0));
    vecs.push_back(mk(3'b001, 32'h1234ABCD, 0, 0, 3'b001, 32'h1234ABCD, 1, 1));    // 5
    vecs.push_back(mk(3'b001, 32'h1234ABCD, 0, 0, 3'b001, 32'h1234ABCD, 1, 0));
    vecs.push_back(mk(3'b001, 32'h1234ABCD, 0, 0, 3'b001, 32'h1234ABCD, 1, 0));
    vecs.push_back(mk(3'b001, 32'h1234ABCD, 0, 0, 3'b001, 32'h1234ABCD, 1, 0));
    vecs.push_back(mk(3'b001, 32'h1234ABCD, 0, 0, 3'b001, 32'h1234ABCD, 1, 1));    // 9
    for (int i = 0; i < 3; i++) begin
      logic [2:0]  g;
      logic [31:0] dd;
      g  = (i == 0) ? 3'b010 : (i == 1) ? 3'b100 : 3'b001;
      dd = (i == 0) ? 32'hB  : (i == 1) ? 32'hC  : 32'hA;
      for (int c = 0; c < HOLD; c++)
        vecs.push_back(mk(3'b111, 32'hA, 32'hB, 32'hC, g, dd, 1, c == HOLD - 1));  // 10..21
    end
    vecs.push_back(mk(3'b111, 32'hA, 32'h55, 32'hC, 3'b010, 32'h55, 1, 0));       // 22
    vecs.push_back(mk(3'b000, 32'hA, 32'h99, 32'hC, 3'b010, 32'h55, 1, 0));
    vecs.push_back(mk(3'b000, 32'hA, 32'h99, 32'hC, 3'b010, 32'h55, 1, 0));
    vecs.push_back(mk(3'b000, 32'hA, 32'h99, 32'hC, 3'b010, 32'h55, 1, 1));        // 25
    vecs.push_back(mk(3'b000, 32'hA, 32'h99, 32'hC, 3'b000, 32'h55, 1, 0));
    vecs.push_back(mk(3'b000, 32'hA, 32'h99, 32'hC, 3'b000, 32'h55, 1, 0));
    vecs.push_back(mk(3'b001, 32'h1, 0, 0, 3'b001, 32'h1, 1, 0));                  // 28
    vecs.push_back(mk(3'b001, 32'h2, 0, 0, 3'b001, 32'h2, 1, 0));
    vecs.push_back(mk(3'b001, 32'h3, 0, 32'h77, 3'b001, 32'h3, 1, 0));
    vecs.push_back(mk(3'b001, 32'h3, 0, 32'h77, 3'b001, 32'h3, 1, 1));            // 31
    vecs.push_back(mk(3'b100, 32'h3, 0, 32'hC0FFEE, 3'b100, 32'hC0FFEE, 1, 0));
    vecs.push_back(mk(3'b100, 32'h3, 0, 32'hC0FFEE, 3'b100, 32'hC0FFEE, 1, 0));    // 33

    rst = 1'b1; req = '0; d0 = '0; d1 = '0; d2 = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset", 3'b000, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;

`ifndef SEG_ARB_PREEMPT_EN
    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].d2);
      check_all($sformatf("vec%0d", i), vecs[i].grant, vecs[i].data, vecs[i].valid, vecs[i].hd);
    end

    // asynchronous reset while owner 2 holds, sampled well before the next edge
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 3'b000, 32'h0, 1'b0, 1'b0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(3'b000, 32'h5, 32'h6, 32'h7);
      check_all($sformatf("post_rst%0d", i), 3'b000, 32'h0, 1'b0, 1'b0);
    end
`else
    step(3'b100, 0, 0, 32'hC);
    check_all("pre_own2", 3'b100, 32'hC, 1'b1, 1'b0);
    step(3'b100, 0, 0, 32'hC);
    check_all("pre_own2_c1", 3'b100, 32'hC, 1'b1, 1'b0);
    step(3'b101, 32'h5, 0, 32'hC);
    check_all("preempt", 3'b001, 32'h5, 1'b1, 1'b0);
    for (int c = 1; c < HOLD; c++) begin
      step(3'b101, 32'h5, 0, 32'hC);
      check_all($sformatf("own0_c%0d", c), 3'b001, 32'h5, 1'b1, c == HOLD - 1);
    end
    step(3'b101, 32'h5, 0, 32'hC);
    check_all("rr_after_preempt", 3'b100, 32'hC, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
